mon_scoreboard: RTL and testbench

//  In-order scoreboard monitor for arithmetic DUTs: computes the expected result of each input

---
 rtl/mon_pkg.sv | 36 +++
 rtl/mon_fifo.sv | 69 ++++++
 rtl/mon_scoreboard.sv | 200 ++++++++++++++++++++
 tb/tb_mon_scoreboard.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared definitions for the in-order scoreboard monitor.
// Holds the operation encoding and the arithmetic reference model used to
// compute the expected result of each input transaction.
package mon_pkg;

  // Operation encoding carried on i_op.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Widest operand the reference model handles. Callers zero-extend their
  // operands to this width and truncate the result back to their own width.
  // Truncating a mod-2^64 result to WIDTH bits gives the mod-2^WIDTH result,
  // so the model is exact for any WIDTH up to REF_MAX_W.
  localparam int REF_MAX_W = 64;

  // Reference result of op(a, b) modulo 2^REF_MAX_W.
  function automatic logic [REF_MAX_W-1:0] ref_calc(
    input logic [1:0]           op,
    input logic [REF_MAX_W-1:0] a,
    input logic [REF_MAX_W-1:0] b
  );
    logic [REF_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mon_fifo.sv
// Synchronous expected-result FIFO for the scoreboard monitor.
// Pointers carry one extra MSB so full and empty are distinguished without a
// separate counter; occupancy is the pointer difference.
// Handshake: push_i writes wdata_i when the caller has already checked room
// (or is popping in the same cycle); pop_i consumes rdata_o, which is the
// head entry presented combinationally whenever the FIFO is not empty.
module mon_fifo
  import mon_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  // Next pointer values; a flush returns both to the origin.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared asynchronously so queued entries are lost on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mon_scoreboard.sv
// In-order scoreboard monitor for arithmetic DUTs.
// Each accepted input transaction (a, b, op) is turned into an expected
// result by the reference model and queued; each DUT result pops the head
// entry and is compared bitwise, with the outcome registered one cycle later.
// Optional feature macro: MON_FIRST_ERR_EN builds first-mismatch capture
// registers behind the o_ferr_* ports; without it those ports are tied to 0.
//
// Traffic semantics: i_in_valid and i_out_valid are single-cycle strobes with
// no back-pressure. They are honoured only while o_mon_ready is high. An input
// strobe is dropped (and o_overflow set) only when the FIFO is full and no
// result is popping in the same cycle; a result strobe with an empty FIFO is
// an underflow and produces no comparison. There is no bypass path, so a
// result can never match a push made in the same cycle.
module mon_scoreboard
  import mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_in_valid,
  input  logic [1:0]              i_op,
  input  logic [WIDTH-1:0]        i_dut_ia,
  input  logic [WIDTH-1:0]        i_dut_ib,
  input  logic                    i_out_valid,
  input  logic [WIDTH-1:0]        i_dut_os,
  output logic                    o_mon_ready,
  output logic                    o_cmp_valid,
  output logic [WIDTH-1:0]        o_diff,
  output logic                    o_mismatch,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [CNT_W-1:0]        o_txn_cnt,
  output logic [CNT_W-1:0]        o_err_cnt,
  output logic                    o_overflow,
  output logic                    o_underflow,
  output logic                    o_ferr_valid,
  output logic [WIDTH-1:0]        o_ferr_exp,
  output logic [WIDTH-1:0]        o_ferr_got,
  output logic [CNT_W-1:0]        o_ferr_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       RDY_ON  = 2'd2;

  // ---------------------------------------------------------------------------
  // Start-up ready counter: 0 -> 1 -> 2 after reset, then holds.
  // ---------------------------------------------------------------------------
  logic [1:0] ready_q, ready_d;
  logic       mon_ready;

  // Advance the ready counter until it reaches the ready state.
  always_comb begin
    ready_d = ready_q;
    if (ready_q != RDY_ON) ready_d = ready_q + 2'd1;
  end

  // Ready counter register; i_clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 2'd0;
    else       ready_q <= ready_d;
  end

  assign mon_ready   = (ready_q == RDY_ON);
  assign o_mon_ready = mon_ready;

  // ---------------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------------
  logic             in_act, out_act;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] exp_w;
  logic [WIDTH-1:0] head_exp;
  logic [WIDTH-1:0] diff_d;
  logic             miss_d;

  // Traffic is invisible until the monitor has finished its start-up count.
  assign in_act  = i_in_valid  & mon_ready;
  assign out_act = i_out_valid & mon_ready;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = out_act & ~fifo_empty;
  assign push    = in_act & (~fifo_full | pop);
  assign ovf_set = in_act & fifo_full & ~pop;
  assign unf_set = out_act & fifo_empty;

  // Expected value for the incoming transaction, reduced to WIDTH bits.
  assign exp_w = WIDTH'(ref_calc(i_op, REF_MAX_W'(i_dut_ia), REF_MAX_W'(i_dut_ib)));

  assign diff_d = head_exp ^ i_dut_os;
  assign miss_d = |diff_d;

  mon_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clear_i (i_clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (exp_w),
    .rdata_o (head_exp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

  // ---------------------------------------------------------------------------
  // Compare stage, counters and sticky flags
  // ---------------------------------------------------------------------------
  logic             cmp_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             mismatch_q;
  logic [CNT_W-1:0] txn_q, err_q;
  logic             ovf_q, unf_q;

  // Register the comparison outcome one cycle after the pop and keep the
  // saturating counters and sticky error flags; i_clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_valid_q <= 1'b0;
      diff_q      <= '0;
      mismatch_q  <= 1'b0;
      txn_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (i_clear) begin
      cmp_valid_q <= 1'b0;
      diff_q      <= '0;
      mismatch_q  <= 1'b0;
      txn_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      cmp_valid_q <= pop;
      diff_q      <= pop ? diff_d : '0;
      mismatch_q  <= pop & miss_d;
      if (pop && (txn_q != CNT_MAX))           txn_q <= txn_q + CNT_ONE;
      if (pop && miss_d && (err_q != CNT_MAX)) err_q <= err_q + CNT_ONE;
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign o_cmp_valid = cmp_valid_q;
  assign o_diff      = diff_q;
  assign o_mismatch  = mismatch_q;
  assign o_txn_cnt   = txn_q;
  assign o_err_cnt   = err_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

  // ---------------------------------------------------------------------------
  // First-mismatch capture
  // ---------------------------------------------------------------------------
`ifdef MON_FIRST_ERR_EN
  logic             ferr_valid_q;
  logic [WIDTH-1:0] ferr_exp_q, ferr_got_q;
  logic [CNT_W-1:0] ferr_idx_q;

  // Latch the first mismatching compare; the index is the pre-increment count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_valid_q <= 1'b0;
      ferr_exp_q   <= '0;
      ferr_got_q   <= '0;
      ferr_idx_q   <= '0;
    end else if (i_clear) begin
      ferr_valid_q <= 1'b0;
      ferr_exp_q   <= '0;
      ferr_got_q   <= '0;
      ferr_idx_q   <= '0;
    end else if (pop && miss_d && !ferr_valid_q) begin
      ferr_valid_q <= 1'b1;
      ferr_exp_q   <= head_exp;
      ferr_got_q   <= i_dut_os;
      ferr_idx_q   <= txn_q;
    end
  end

  assign o_ferr_valid = ferr_valid_q;
  assign o_ferr_exp   = ferr_exp_q;
  assign o_ferr_got   = ferr_got_q;
  assign o_ferr_idx   = ferr_idx_q;
`else
  assign o_ferr_valid = 1'b0;
  assign o_ferr_exp   = '0;
  assign o_ferr_got   = '0;
  assign o_ferr_idx   = '0;
`endif

endmodule

// File: tb/tb_mon_scoreboard.sv
// Testbench for mon_scoreboard: directed scenarios plus randomized
// back-to-back traffic, checked against a queue-based behavioural model.
module tb_mon_scoreboard;

  localparam int W       = 32;
  localparam int D       = 8;
  localparam int CW      = 4;
  localparam int AW      = $clog2(D);
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          i_clear     = 1'b0;
  logic          i_in_valid  = 1'b0;
  logic [1:0]    i_op        = 2'b00;
  logic [W-1:0]  i_dut_ia    = '0;
  logic [W-1:0]  i_dut_ib    = '0;
  logic          i_out_valid = 1'b0;
  logic [W-1:0]  i_dut_os    = '0;
  logic          o_mon_ready;
  logic          o_cmp_valid;
  logic [W-1:0]  o_diff;
  logic          o_mismatch;
  logic [AW:0]   o_level;
  logic [CW-1:0] o_txn_cnt;
  logic [CW-1:0] o_err_cnt;
  logic          o_overflow;
  logic          o_underflow;
  logic          o_ferr_valid;
  logic [W-1:0]  o_ferr_exp;
  logic [W-1:0]  o_ferr_got;
  logic [CW-1:0] o_ferr_idx;

  mon_scoreboard #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (i_clear),
    .i_in_valid   (i_in_valid),
    .i_op         (i_op),
    .i_dut_ia     (i_dut_ia),
    .i_dut_ib     (i_dut_ib),
    .i_out_valid  (i_out_valid),
    .i_dut_os     (i_dut_os),
    .o_mon_ready  (o_mon_ready),
    .o_cmp_valid  (o_cmp_valid),
    .o_diff       (o_diff),
    .o_mismatch   (o_mismatch),
    .o_level      (o_level),
    .o_txn_cnt    (o_txn_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow),
    .o_ferr_valid (o_ferr_valid),
    .o_ferr_exp   (o_ferr_exp),
    .o_ferr_got   (o_ferr_got),
    .o_ferr_idx   (o_ferr_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model: an expected queue plus plain counters and flags.
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           m_txn, m_err, m_fidx;
  bit           m_ovf, m_unf, m_cmp, m_fv;
  logic [W-1:0] m_diff, m_fexp, m_fgot;

  function automatic logic [W-1:0] model_calc(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a * b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_txn = 0; m_err = 0; m_fidx = 0;
    m_ovf = 0; m_unf = 0; m_cmp = 0; m_fv = 0;
    m_diff = '0; m_fexp = '0; m_fgot = '0;
  endtask

  // Driver: apply one cycle of stimulus at a negedge, let the active edge
  // happen, update the model, and return at the following negedge.
  task automatic step(input logic clr, input logic in_v, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic out_v, input logic [W-1:0] os);
    logic [W-1:0] e;
    bit           was_full, popped;
    i_clear = clr; i_in_valid = in_v; i_op = op; i_dut_ia = a; i_dut_ib = b;
    i_out_valid = out_v; i_dut_os = os;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      was_full = (exp_q.size() == D);
      popped   = 0;
      m_cmp    = 0;
      m_diff   = '0;
      if (out_v) begin
        if (exp_q.size() == 0) begin
          m_unf = 1;
        end else begin
          e      = exp_q.pop_front();
          popped = 1;
          m_cmp  = 1;
          m_diff = e ^ os;
          if (m_diff != 0 && !m_fv) begin
            m_fv = 1; m_fexp = e; m_fgot = os; m_fidx = m_txn;
          end
          if (m_txn < CNT_MAX) m_txn++;
          if (m_diff != 0 && m_err < CNT_MAX) m_err++;
        end
      end
      if (in_v) begin
        if (!was_full || popped) exp_q.push_back(model_calc(op, a, b));
        else                     m_ovf = 1;
      end
    end
    @(negedge clk);
    i_clear = 1'b0; i_in_valid = 1'b0; i_out_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    i_in_valid = 1'b1; i_out_valid = 1'b1; i_op = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({o_mon_ready, o_cmp_valid, o_mismatch, o_overflow, o_underflow} !== 5'b0 ||
        o_level !== '0 || o_txn_cnt !== '0 || o_err_cnt !== '0 || o_diff !== '0) begin
      n_fail++; $display("FAIL reset_state: ready=%0b lvl=%0d txn=%0d diff=%0h, want all 0",
                         o_mon_ready, o_level, o_txn_cnt, o_diff);
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_mon_ready !== (k == 2)) begin
        n_fail++; $display("FAIL ready_seq[%0d]: got %0b want %0b", k, o_mon_ready, k == 2);
      end
    end
    n_tests++;
    if (o_level !== '0 || o_underflow !== 1'b0 || o_cmp_valid !== 1'b0) begin
      n_fail++; $display("FAIL pre_ready_ignored: lvl=%0d unf=%0b cmp=%0b want 0,0,0",
                         o_level, o_underflow, o_cmp_valid);
    end
    i_in_valid = 1'b0; i_out_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_add();
    step(1'b0, 1'b1, 2'b00, 32'd5, 32'd7, 1'b0, '0);
    idle();
    step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 32'd12);
    n_tests++;
    if (o_cmp_valid !== 1'b1 || o_diff !== '0 || o_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL add_cmp: cmp=%0b diff=%0h mm=%0b want 1,0,0", o_cmp_valid, o_diff, o_mismatch);
    end
    n_tests++;
    if (o_txn_cnt !== CW'(1) || o_err_cnt !== CW'(0)) begin
      n_fail++; $display("FAIL add_cnt: txn=%0d err=%0d want 1,0", o_txn_cnt, o_err_cnt);
    end
    idle();
    n_tests++;
    if (o_cmp_valid !== 1'b0 || o_diff !== '0) begin
      n_fail++; $display("FAIL cmp_pulse: cmp=%0b diff=%0h want 0,0", o_cmp_valid, o_diff);
    end
  endtask

  task automatic test_mul_mismatch();
    step(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0, '0);
    step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 32'h0000_0001);
    n_tests++;
    if (o_diff !== 32'hFFFF_FFFF || o_mismatch !== 1'b1 || o_err_cnt !== CW'(1)) begin
      n_fail++; $display("FAIL mul_mismatch: diff=%0h mm=%0b err=%0d want ffffffff,1,1",
                         o_diff, o_mismatch, o_err_cnt);
    end
    n_tests++;
`ifdef MON_FIRST_ERR_EN
    if (o_ferr_valid !== 1'b1 || o_ferr_exp !== 32'hFFFF_FFFE || o_ferr_got !== 32'h1 ||
        o_ferr_idx !== CW'(0)) begin
      n_fail++; $display("FAIL ferr_capture: v=%0b exp=%0h got=%0h idx=%0d want 1,fffffffe,1,0",
                         o_ferr_valid, o_ferr_exp, o_ferr_got, o_ferr_idx);
    end
`else
    if (o_ferr_valid !== 1'b0 || o_ferr_exp !== '0 || o_ferr_got !== '0 || o_ferr_idx !== '0) begin
      n_fail++; $display("FAIL ferr_tied: v=%0b exp=%0h got=%0h idx=%0d want 0",
                         o_ferr_valid, o_ferr_exp, o_ferr_got, o_ferr_idx);
    end
`endif
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
    for (int k = 0; k < D + 1; k++) step(1'b0, 1'b1, 2'b00, W'(k), W'(100), 1'b0, '0);
    n_tests++;
    if (o_level !== (AW+1)'(D) || o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow: lvl=%0d ovf=%0b want %0d,1", o_level, o_overflow, D);
    end
    step(1'b0, 1'b1, 2'b11, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, exp_q[0]);
    n_tests++;
    if (o_level !== (AW+1)'(D) || o_cmp_valid !== 1'b1 || o_diff !== '0) begin
      n_fail++; $display("FAIL full_push_pop: lvl=%0d cmp=%0b diff=%0h want %0d,1,0",
                         o_level, o_cmp_valid, o_diff, D);
    end
    // Drain and confirm the wrapped entries come out in order.
    while (exp_q.size() != 0) step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, exp_q[0]);
    n_tests++;
    if (o_level !== '0 || o_err_cnt !== '0 || o_txn_cnt !== CW'(m_txn)) begin
      n_fail++; $display("FAIL drain_order: lvl=%0d err=%0d txn=%0d want 0,0,%0d",
                         o_level, o_err_cnt, o_txn_cnt, m_txn);
    end
  endtask

  task automatic test_underflow_clear();
    step(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
    step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 32'h1234);
    n_tests++;
    if (o_underflow !== 1'b1 || o_cmp_valid !== 1'b0) begin
      n_fail++; $display("FAIL underflow: unf=%0b cmp=%0b want 1,0", o_underflow, o_cmp_valid);
    end
    step(1'b1, 1'b1, 2'b00, 32'd1, 32'd2, 1'b0, '0);
    n_tests++;
    if (o_level !== '0 || o_underflow !== 1'b0 || o_overflow !== 1'b0 || o_txn_cnt !== '0 ||
        o_err_cnt !== '0 || o_mon_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_wins: lvl=%0d unf=%0b txn=%0d ready=%0b want 0,0,0,1",
                         o_level, o_underflow, o_txn_cnt, o_mon_ready);
    end
    // Same-cycle push and result into an empty FIFO: no bypass.
    step(1'b0, 1'b1, 2'b00, 32'd3, 32'd4, 1'b1, 32'd7);
    n_tests++;
    if (o_underflow !== 1'b1 || o_level !== (AW+1)'(1) || o_cmp_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_bypass: unf=%0b lvl=%0d cmp=%0b want 1,1,0",
                         o_underflow, o_level, o_cmp_valid);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
    for (int k = 0; k < 21; k++) begin
      if (exp_q.size() != 0)
        step(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1, exp_q[0] ^ 32'h1);
      else
        step(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0, '0);
    end
    n_tests++;
    if (o_err_cnt !== CW'(CNT_MAX) || o_txn_cnt !== CW'(CNT_MAX)) begin
      n_fail++; $display("FAIL saturation: txn=%0d err=%0d want %0d,%0d",
                         o_txn_cnt, o_err_cnt, CNT_MAX, CNT_MAX);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, os;
    logic         iv, ov, clr;
    step(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
    for (int k = 0; k < 400; k++) begin
      a   = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      iv  = ($urandom_range(0, 3) != 0);
      ov  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 79) == 0);
      os  = (exp_q.size() != 0 && $urandom_range(0, 3) != 0) ? exp_q[0] : $urandom;
      step(clr, iv, 2'($urandom_range(0, 3)), a, b, ov, os);
      n_tests++;
      if (o_cmp_valid !== m_cmp || o_diff !== m_diff || o_mismatch !== (m_diff != 0)) begin
        n_fail++; $display("FAIL rand_cmp[%0d]: cmp=%0b diff=%0h mm=%0b want %0b,%0h,%0b",
                           k, o_cmp_valid, o_diff, o_mismatch, m_cmp, m_diff, m_diff != 0);
      end
      n_tests++;
      if (o_level !== (AW+1)'(exp_q.size()) || o_txn_cnt !== CW'(m_txn) || o_err_cnt !== CW'(m_err)) begin
        n_fail++; $display("FAIL rand_state[%0d]: lvl=%0d txn=%0d err=%0d want %0d,%0d,%0d",
                           k, o_level, o_txn_cnt, o_err_cnt, exp_q.size(), m_txn, m_err);
      end
      n_tests++;
      if (o_overflow !== m_ovf || o_underflow !== m_unf) begin
        n_fail++; $display("FAIL rand_flags[%0d]: ovf=%0b unf=%0b want %0b,%0b",
                           k, o_overflow, o_underflow, m_ovf, m_unf);
      end
`ifdef MON_FIRST_ERR_EN
      n_tests++;
      if (o_ferr_valid !== m_fv || o_ferr_exp !== m_fexp || o_ferr_got !== m_fgot ||
          o_ferr_idx !== CW'(m_fidx)) begin
        n_fail++; $display("FAIL rand_ferr[%0d]: v=%0b exp=%0h got=%0h idx=%0d want %0b,%0h,%0h,%0d",
                           k, o_ferr_valid, o_ferr_exp, o_ferr_got, o_ferr_idx, m_fv, m_fexp, m_fgot, m_fidx);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b01, $urandom, $urandom, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (o_level !== '0 || o_mon_ready !== 1'b0 || o_txn_cnt !== '0) begin
      n_fail++; $display("FAIL reset_mid: lvl=%0d ready=%0b txn=%0d want 0,0,0",
                         o_level, o_mon_ready, o_txn_cnt);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    n_tests++;
    if (o_mon_ready !== 1'b1 || o_level !== '0) begin
      n_fail++; $display("FAIL ready_again: ready=%0b lvl=%0d want 1,0", o_mon_ready, o_level);
    end
    step(1'b0, 1'b1, 2'b01, 32'd3, 32'd5, 1'b0, '0);
    step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 32'hFFFF_FFFE);
    n_tests++;
    if (o_cmp_valid !== 1'b1 || o_diff !== '0 || o_txn_cnt !== CW'(1)) begin
      n_fail++; $display("FAIL sub_after_reset: cmp=%0b diff=%0h txn=%0d want 1,0,1",
                         o_cmp_valid, o_diff, o_txn_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    test_reset();
    test_add();
    test_mul_mismatch();
    test_overflow();
    test_underflow_clear();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
